alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 64-bit combinational alu between NREQ requesters. Each op is accepted
//  on a valid/ready handshake under round-robin arbitration, then driven onto the alu from
//  registered operands. The result is captured and returned on a shared response channel.
//  Sits between the issue logic and the alu instance; the alu itself is outside this block.
// PARAMETERS
//  NREQ   2   number of requesters (2..8)
//  OPW    12  alu_control width; one-hot encoding, 12'h800 = ADD
//  DW     64  operand/result width
// PORTS
//  clk          in   1         clock; all state on rising edge
//  resetn       in   1         async reset, active-low
//  req_valid    in   NREQ      per-requester op valid
//  req_ready    out  NREQ      per-requester accept strobe; at most one bit high
//  req_op       in   NREQ*OPW  op of requester i at [i*OPW +: OPW]
//  req_src1     in   NREQ*DW   src1 of requester i at [i*DW +: DW]
//  req_src2     in   NREQ*DW   src2 of requester i at [i*DW +: DW]
//  alu_control  out  OPW       to alu; registered
//  alu_src1     out  DW        to alu; registered
//  alu_src2     out  DW        to alu; registered
//  alu_result   in   DW        from alu; combinational function of the three above
//  rsp_valid    out  NREQ      one-hot: the requester whose response is pending
//  rsp_ready    in   NREQ      per-requester response accept
//  rsp_result   out  DW        result of the pending response
//  rsp_err      out  1         pending op was not one-hot; rsp_result = 0
//  ops_done     out  32        count of completed responses; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset values
//  - State goes to IDLE. All outputs are 0.
//  - Round-robin pointer last = NREQ-1, so requester 0 wins first.
//  FSM: IDLE -> EXEC -> RESP -> IDLE. One op in flight; minimum 3 cycles per op.
//  IDLE
//  - Winner = first i with req_valid[i], searching last+1, last+2, ... mod NREQ.
//  - req_ready[winner] = 1 in the same cycle. This is combinational from req_valid and state.
//  - At the edge: latch op/src1/src2 into alu_control/alu_src1/alu_src2, latch owner = winner,
//    go to EXEC.
//  - If no req_valid bit is set: stay in IDLE; the alu registers hold their values.
//  EXEC
//  - req_ready = 0.
//  - If alu_control is one-hot: rsp_result <= alu_result, rsp_err <= 0.
//  - Otherwise (zero or multi-hot): rsp_result <= 0, rsp_err <= 1.
//  - Go to RESP.
//  RESP
//  - rsp_valid[owner] = 1 and holds until rsp_ready[owner] = 1.
//  - rsp_ready bits of other requesters are ignored.
//  - On acceptance: last <= owner, ops_done <= ops_done + 1, go to IDLE.
//  - rsp_valid drops in the cycle after acceptance.
//  - A requester may re-assert req_valid while its response is pending; the request is
//    considered in the next IDLE cycle.
//  Stability and ordering
//  - rsp_result and rsp_err are stable while rsp_valid is high.
//  - alu_* do not change outside the IDLE accept edge.
//  - A requester that drops req_valid in IDLE before being granted loses nothing; no state
//    changes.
//  Async reset at any point: FSM to IDLE, all outputs cleared. Any in-flight op is dropped
//  with no response.
// TESTING
//  1 Single: req0 op=12'h800, src1=5, src2=7 -> req_ready[0] for 1 cycle; rsp_valid=2'b01
//    two edges later; rsp_result=12; rsp_err=0; ops_done=1.
//  2 Fairness: req_valid=2'b11 held with rsp_ready=2'b11 -> grants alternate 0,1,0,1; each
//    response 3 cycles apart.
//  3 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_result are held; no new
//    req_ready. Raise rsp_ready -> accepted; back in IDLE next cycle.
//  4 Bad op: req1 op=12'h003 -> rsp_valid=2'b10, rsp_err=1, rsp_result=0; ops_done
//    increments.
//  5 Reset mid-op: deassert resetn in EXEC -> all outputs 0 immediately; no rsp_valid after
//    release; requester 0 wins next.
//  6 Wrap: force ops_done=32'hFFFFFFFF, complete one op -> ops_done=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one external combinational
// ALU between NREQ requesters. One op is in flight at a time:
// accept (IDLE) -> execute (EXEC) -> respond (RESP) -> IDLE.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int OPW  = 12,
  parameter int DW   = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_src1,
  input  logic [NREQ*DW-1:0]  req_src2,
  output logic [OPW-1:0]      alu_control,
  output logic [DW-1:0]       alu_src1,
  output logic [DW-1:0]       alu_src2,
  input  logic [DW-1:0]       alu_result,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic                rsp_err,
  output logic [31:0]         ops_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     owner_q;
  logic [OPW-1:0]    alu_control_q;
  logic [DW-1:0]     alu_src1_q;
  logic [DW-1:0]     alu_src2_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DW-1:0]     rsp_result_q;
  logic              rsp_err_q;
  logic [31:0]       ops_done_q;

  logic              grant_vld;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     cand;

  // Zero or multi-hot controls are reported as errors instead of being executed.
  function automatic logic is_onehot(input logic [OPW-1:0] x);
    return (x != '0) && ((x & (x - OPW'(1))) == '0);
  endfunction

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Accept strobe is combinational so the winner sees it in the same IDLE cycle.
  always_comb begin
    req_ready = '0;
    if (resetn && (state_q == IDLE) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Single FSM: latches the winning op, captures the ALU result, holds the response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      last_q        <= IW'(NREQ - 1);
      owner_q       <= '0;
      alu_control_q <= '0;
      alu_src1_q    <= '0;
      alu_src2_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_err_q     <= 1'b0;
      ops_done_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            alu_control_q <= req_op[grant_idx*OPW +: OPW];
            alu_src1_q    <= req_src1[grant_idx*DW +: DW];
            alu_src2_q    <= req_src2[grant_idx*DW +: DW];
            owner_q       <= grant_idx;
            state_q       <= EXEC;
          end
        end
        EXEC: begin
          if (is_onehot(alu_control_q)) begin
            rsp_result_q <= alu_result;
            rsp_err_q    <= 1'b0;
          end else begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
          end
          rsp_valid_q <= NREQ'(1) << owner_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            last_q      <= owner_q;
            ops_done_q  <= ops_done_q + 32'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_control = alu_control_q;
  assign alu_src1    = alu_src1_q;
  assign alu_src2    = alu_src2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_err     = rsp_err_q;
  assign ops_done    = ops_done_q;

endmodule
